// File: rtl/dt_estimator_pkg.sv
// Shared types, constants and saturation helper for the dT estimator.
package dt_est_pkg;

    localparam int unsigned DW       = 8;
    localparam int unsigned PW       = 2 * DW + 1;
    localparam int unsigned DMAX_CAP = 127;

    typedef enum logic [2:0] {
        IDLE,
        DIFF,
        SCALE,
        FILT,
        OUT
    } state_e;

    // Sample operands captured when start is accepted.
    typedef struct packed {
        logic [DW-1:0] t;
        logic [DW-1:0] alpha;
        logic [DW-1:0] k_dt;
        logic [DW-1:0] d_max;
    } sample_t;

    // Clamp a wide signed value to +/-mag (mag <= DMAX_CAP).
    function automatic logic signed [DW-1:0] sat_s8(input logic signed [PW-1:0] v,
                                                    input logic [DW-1:0] mag);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] lo;
        hi = $signed(PW'(mag));
        lo = -hi;
        if (v > hi)
            return DW'(hi);
        else if (v < lo)
            return DW'(lo);
        else
            return DW'(v);
    endfunction

endpackage

// File: rtl/dt_estimator_if.sv
// Control/data bundle between the MMIO block, the estimator and the fuzzy stage.
interface dt_estimator_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic         init;
    logic         en;
    logic [W-1:0] T_in;
    logic [W-1:0] alpha;
    logic [W-1:0] k_dt;
    logic [W-1:0] d_max;
    logic [W-1:0] dT_out;
    logic         busy;
    logic         valid;
    logic         sat;

    modport master (
        output start, init, en, T_in, alpha, k_dt, d_max,
        input  dT_out, busy, valid, sat
    );

    modport slave (
        input  start, init, en, T_in, alpha, k_dt, d_max,
        output dT_out, busy, valid, sat
    );
endinterface

// File: rtl/dt_estimator_ema.sv
// Combinational EMA update: y + ((x - y) * alpha >>> ASHIFT), clamped to +/-dmax_eff.
module dt_ema
    import dt_est_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ASHIFT = 8
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic        [W-1:0] alpha,
    input  logic        [W-1:0] dmax_eff,
    output logic signed [W-1:0] y_next_c
);
    localparam int unsigned EW = W + 1;
    localparam int unsigned MW = 2 * W + 1;

    logic signed [EW-1:0] e_c;
    logic signed [MW-1:0] m_c;
    logic signed [MW-1:0] step_c;
    logic signed [MW-1:0] sum_c;

    // Arithmetic shift floors toward -inf; the final clamp absorbs a lowered d_max.
    always_comb begin
        e_c      = EW'(x) - EW'(y);
        m_c      = MW'(e_c) * MW'($signed({1'b0, alpha}));
        step_c   = m_c >>> ASHIFT;
        sum_c    = MW'(y) + step_c;
        y_next_c = sat_s8(sum_c, dmax_eff);
    end
endmodule

// File: rtl/dt_estimator.sv
// Temperature-derivative estimator: difference, gain, saturation and EMA per accepted sample.
module dt_estimator
    import dt_est_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ASHIFT = 8
) (
    input logic            clk,
    input logic            rst_n,
    dt_estimator_if.slave  bus
);
    localparam int unsigned DIFFW = W + 1;
    localparam int unsigned PRODW = 2 * W + 1;

    state_e state_q;
    state_e state_d;
    logic   accept_c;

    sample_t                 lat_q;
    logic [W-1:0]            t_prev_q;
    logic                    primed_q;
    logic signed [DIFFW-1:0] diff_q;
    logic signed [W-1:0]     x_q;
    logic                    sat_n_q;
    logic signed [W-1:0]     y_q;

    logic [W-1:0]     dt_out_q;
    logic             busy_q;
    logic             valid_q;
    logic             sat_q;

    logic [W-1:0]            dmax_eff_c;
    logic signed [PRODW-1:0] prod_c;
    logic signed [W-1:0]     x_c;
    logic signed [W-1:0]     y_next_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and acceptance; init overrides everything.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        if (bus.init) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && bus.en) begin
                        accept_c = 1'b1;
                        state_d  = DIFF;
                    end
                end
                DIFF:    state_d = SCALE;
                SCALE:   state_d = FILT;
                FILT:    state_d = OUT;
                OUT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Gain and saturation datapath for the SCALE step.
    always_comb begin
        dmax_eff_c = (lat_q.d_max > W'(DMAX_CAP)) ? W'(DMAX_CAP) : lat_q.d_max;
        prod_c     = PRODW'(diff_q) * PRODW'($signed({1'b0, lat_q.k_dt}));
        x_c        = sat_s8(prod_c, dmax_eff_c);
    end

    dt_ema #(
        .W      (W),
        .ASHIFT (ASHIFT)
    ) u_ema (
        .x        (x_q),
        .y        (y_q),
        .alpha    (lat_q.alpha),
        .dmax_eff (dmax_eff_c),
        .y_next_c (y_next_c)
    );

    // Pipeline registers and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q    <= '0;
            t_prev_q <= '0;
            primed_q <= 1'b0;
            diff_q   <= '0;
            x_q      <= '0;
            sat_n_q  <= 1'b0;
            y_q      <= '0;
            dt_out_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state_d != IDLE);
            if (bus.init) begin
                t_prev_q <= bus.T_in;
                y_q      <= '0;
                primed_q <= 1'b1;
                dt_out_q <= '0;
                sat_q    <= 1'b0;
            end else begin
                if (accept_c)
                    lat_q <= '{t: bus.T_in, alpha: bus.alpha, k_dt: bus.k_dt, d_max: bus.d_max};
                unique case (state_q)
                    DIFF: begin
                        // First sample after reset has no history: report zero slope.
                        diff_q   <= primed_q ? (DIFFW'({1'b0, lat_q.t}) - DIFFW'({1'b0, t_prev_q}))
                                             : '0;
                        primed_q <= 1'b1;
                        t_prev_q <= lat_q.t;
                    end
                    SCALE: begin
                        x_q     <= x_c;
                        sat_n_q <= (PRODW'(x_c) != prod_c);
                    end
                    FILT: y_q <= y_next_c;
                    OUT: begin
                        dt_out_q <= y_q;
                        sat_q    <= sat_n_q;
                        valid_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dT_out = dt_out_q;
    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.sat    = sat_q;

endmodule

// File: doc/dt_estimator.md
Name: dt_estimator

Overview:
- Computes the temperature-derivative estimate dT that feeds the MMIO register block's dT_mon input when dt_mode=1.
- Per accepted sample it computes: difference T_in − T_prev, gain k_dt, saturation to ±d_max, then a first-order IIR (EMA) with coefficient alpha.
- Sits between the MMIO register block (start/init strobes, T_reg, alpha, k_dt, d_max) and the fuzzy inference stage, which consumes dT_out.
- Multi-cycle FSM with a busy/valid handshake.

Parameters:
- W, 8, data width of T_in, dT_out and the coefficients.
- ASHIFT, 8, right-shift applied after the alpha multiply (alpha/2^ASHIFT is the EMA gain).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async reset, active-low.
- start  in  1  one-cycle sample strobe (from start_pulse).
- init  in  1  one-cycle estimator reset strobe (from init_pulse).
- en  in  1  estimator enable (tied to dt_mode); start is ignored when 0.
- T_in  in  W  current temperature, unsigned.
- alpha  in  W  EMA coefficient, unsigned.
- k_dt  in  W  derivative gain, unsigned.
- d_max  in  W  saturation magnitude, unsigned.
- dT_out  out  W  filtered dT, two's-complement signed.
- busy  out  1  computation in progress.
- valid  out  1  one-cycle pulse: dT_out updated.
- sat  out  1  last sample was clamped.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following clear to 0: dT_out, busy, valid, sat, T_prev, y, primed. State goes to IDLE.
- States and transitions:
  - IDLE→DIFF→SCALE→FILT→OUT→IDLE, one clock per state.
  - busy = (state != IDLE), so busy is high for exactly 4 cycles.
- Accept rule: start is accepted only when state==IDLE, en==1 and init==0.
  - On the accept edge, latch T_in, alpha, k_dt and d_max into internal registers.
  - Later changes to these inputs do not affect the sample in flight.
  - start while busy, or while en==0: ignored. No queueing, no error.
- dmax_eff = min(d_max, 127).
- DIFF:
  - If primed: diff = T_lat − T_prev, as 9-bit signed, range −255..255.
  - If not primed: diff = 0, and primed is set to 1.
  - In both cases T_prev <= T_lat.
- SCALE:
  - prod = diff × k_dt, 17-bit signed; k_dt is treated as unsigned.
  - x = clamp(prod, −dmax_eff, +dmax_eff), 8-bit signed.
  - sat_n = (x != prod).
- FILT:
  - e = x − y, 9-bit signed.
  - y <= y + ((e × alpha) >>> ASHIFT). The shift is arithmetic, so it floors toward −inf.
  - Then clamp y to ±dmax_eff; this handles d_max lowered between samples.
  - alpha=0 holds y unchanged.
- OUT → IDLE edge:
  - dT_out <= y; sat <= sat_n; valid <= 1 for exactly one cycle.
  - valid is high on the cycle after the 4 busy cycles, with busy=0.
  - A start in that valid cycle is accepted.
- Latency: valid is high 5 cycles after the cycle in which start is accepted.
- init (priority over everything):
  - Aborts any computation and returns state to IDLE.
  - T_prev <= T_in; y <= 0; primed <= 1; dT_out <= 0; sat <= 0.
  - No valid pulse is produced for the aborted sample.
  - init and start in the same cycle: init acts, start is dropped.
- dT_out holds its value between valid pulses.
- en only gates acceptance. Deasserting en mid-computation does not abort the sample in flight.

Decomposition:
- Shared package dt_est_pkg:
  - state enum {IDLE, DIFF, SCALE, FILT, OUT}.
  - Constant DMAX_CAP=127.
  - Function sat_s8(signed value, magnitude) → signed 8-bit.
- Optional sub-module dt_ema: the combinational FILT datapath (e, multiply, shift, clamp). Keeps the FSM file small and lets the filter be unit-tested on its own.

Test Plan:
- Reset with no stimulus -> dT_out=0x00, busy=0, valid=0, sat=0.
- init with T_in=100; then start with T_in=110, k_dt=3, alpha=255, d_max=64 -> busy high for 4 cycles; valid at +5; dT_out=29 (0x1D), sat=0.
- init with T_in=0; start with T_in=200, k_dt=3, alpha=255, d_max=64 -> prod=600 clamped to x=64; dT_out=63 (0x3F); sat=1.
- init with T_in=200; start with T_in=190, k_dt=3, alpha=255, d_max=64 -> x=−30; dT_out=0xE2 (−30), sat=0.
- After reset with no init: start with T_in=50 -> dT_out=0. Then start with T_in=60, k_dt=1, alpha=128 -> dT_out=5. Then start with alpha=0 -> dT_out stays 5.
- Mid-DIFF start -> ignored. init in SCALE state -> busy=0 next cycle, no valid pulse, dT_out=0. start with en=0 -> no response.
